mem_port_arbiter: RTL

Arbiter and sequencer sharing one fixed-latency, single-port memory between the instruction fetch stage (I port) and the memory stage (D port) of the pipelined MIPS core. It accepts word requests from both stages, picks one per access (data over instruction, with an optional anti-starvation guard) and drives the memory port. It returns read data and a completion pulse to the winning requester. The pipeline's hazard logic uses `Busy` and the per-port `Gnt`/`Valid` pulses to stall fetch or memory stages.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the I-fetch and D-memory stages.
// Define ARB_STARVE_GUARD_EN to let I win a contested access after STARVE_LIMIT straight losses.
module mem_port_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IGnt,
    output logic        IValid,
    output logic [31:0] IRData,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DGnt,
    output logic        DValid,
    output logic [31:0] DRData,
    output logic        MemEn,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    output logic        Busy
);

    if (LATENCY < 1 || LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("mem_port_arbiter: LATENCY and STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        win_d_q, win_d_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        arb_c;
    logic        pick_d;
    logic        force_i;
    logic        cap;

    assign arb_c  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign pick_d = DReq && !force_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    // Counts contested D wins; reaching the limit hands the next contested access to I.
    assign force_i = IReq && DReq && (starve_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (arb_c && (IReq || DReq)) begin
            if (!pick_d) begin
                starve_d = '0;
            end else if (IReq) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Memory data is valid in ISSUE itself for LATENCY=1, else on the last WAIT cycle.
    assign cap = ((state_q == S_ISSUE) && (LATENCY == 1)) ||
                 ((state_q == S_WAIT) && (cnt_q == 4'd1));

    always_comb begin
        state_d     = state_q;
        win_d_d     = win_d_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (IReq || DReq) begin
                    state_d    = S_ISSUE;
                    win_d_d    = pick_d;
                    we_d       = pick_d && DWrite;
                    mem_en_d   = 1'b1;
                    mem_we_d   = pick_d && DWrite;
                    mem_addr_d = pick_d ? DAddr : IAddr;
                    if (pick_d) begin
                        mem_wdata_d = DWData;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'(LATENCY - 1);
                state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap) begin
            if (!win_d_q) begin
                irdata_d = MemRData;
            end else if (!we_q) begin
                drdata_d = MemRData;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            win_d_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            win_d_q     <= win_d_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    assign IGnt     = (state_q == S_ISSUE) && !win_d_q;
    assign DGnt     = (state_q == S_ISSUE) && win_d_q;
    assign IValid   = (state_q == S_DONE) && !win_d_q;
    assign DValid   = (state_q == S_DONE) && win_d_q;
    assign Busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign MemEn    = mem_en_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign IRData   = irdata_q;
    assign DRData   = drdata_q;

endmodule
